// File: rtl/red_pitaya_fads_pkg.sv
// Shared types and constants for the FADS droplet sorter.
package red_pitaya_fads_pkg;

    localparam int unsigned DEF_DW = 14;
    localparam int unsigned DEF_CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DROPLET = 2'd1,
        ST_DELAY   = 2'd2,
        ST_FIRE    = 2'd3
    } fads_state_e;

    // Largest value representable in a cw-bit counter (width saturation point).
    function automatic int unsigned sat_max(input int unsigned cw);
        return (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/red_pitaya_fads_timer.sv
// Loadable down-counter shared by the DELAY and FIRE phases of the sorter.
module red_pitaya_fads_timer
    import red_pitaya_fads_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] cnt_q;

    // done is high during the last counted cycle (count at 1 or already 0)
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (load) begin
            cnt_q <= value;
            done  <= (value <= CW'(1));
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            done  <= (cnt_q <= CW'(2));
        end else begin
            done  <= 1'b1;
        end
    end

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// Droplet detector/measurer with peak and width windows and a delayed,
// fixed-length sort trigger for the ASG.
module red_pitaya_fads_sorter
    import red_pitaya_fads_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned CW = DEF_CW
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic signed [DW-1:0] adc_i,
    input  logic                 enable_i,
    input  logic signed [DW-1:0] det_thr_i,
    input  logic signed [DW-1:0] low_thr_i,
    input  logic signed [DW-1:0] high_thr_i,
    input  logic        [CW-1:0] min_width_i,
    input  logic        [CW-1:0] max_width_i,
    input  logic        [CW-1:0] sort_delay_i,
    input  logic        [CW-1:0] sort_len_i,
    output logic                 sort_trig_o,
    output logic                 meas_valid_o,
    output logic signed [DW-1:0] last_peak_o,
    output logic        [CW-1:0] last_width_o,
    output logic                 last_sorted_o,
    output logic        [31:0]   droplet_cnt_o,
    output logic        [31:0]   sorted_cnt_o,
    output logic        [1:0]    state_o
);

    localparam logic [CW-1:0] WIDTH_SAT = CW'(sat_max(CW));

    fads_state_e          state_q, state_d;
    logic signed [DW-1:0] adc_q, peak_q;
    logic        [CW-1:0] width_q, len_q;
    logic                 armed_q;
    logic                 tmr_load_c, tmr_done;
    logic        [CW-1:0] tmr_value_c;
    logic                 above_c, decide_c, sort_c;

    assign above_c  = adc_q > det_thr_i;
    assign decide_c = enable_i && (state_q == ST_DROPLET) && !above_c;
    assign sort_c   = (low_thr_i < peak_q) && (peak_q < high_thr_i) &&
                      (width_q >= min_width_i) && (width_q <= max_width_i);
    assign state_o  = state_q;

    red_pitaya_fads_timer #(.CW(CW)) u_timer (
        .adc_clk_i  (adc_clk_i),
        .adc_rstn_i (adc_rstn_i),
        .load       (tmr_load_c),
        .value      (tmr_value_c),
        .done       (tmr_done)
    );

    // Next-state and timer-load decode
    always_comb begin
        state_d     = state_q;
        tmr_load_c  = 1'b0;
        tmr_value_c = '0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && above_c) state_d = ST_DROPLET;
                end
                ST_DROPLET: begin
                    if (!above_c) begin
                        if (sort_c && (sort_delay_i != '0)) begin
                            state_d     = ST_DELAY;
                            tmr_load_c  = 1'b1;
                            tmr_value_c = sort_delay_i;
                        end else if (sort_c && (sort_len_i != '0)) begin
                            state_d     = ST_FIRE;
                            tmr_load_c  = 1'b1;
                            tmr_value_c = sort_len_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_done) begin
                        if (len_q != '0) begin
                            state_d     = ST_FIRE;
                            tmr_load_c  = 1'b1;
                            tmr_value_c = len_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FIRE: begin
                    if (tmr_done) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q       <= ST_IDLE;
            adc_q         <= '0;
            armed_q       <= 1'b0;
            peak_q        <= '0;
            width_q       <= '0;
            len_q         <= '0;
            sort_trig_o   <= 1'b0;
            meas_valid_o  <= 1'b0;
            last_peak_o   <= '0;
            last_width_o  <= '0;
            last_sorted_o <= 1'b0;
            droplet_cnt_o <= '0;
            sorted_cnt_o  <= '0;
        end else begin
            state_q      <= state_d;
            adc_q        <= adc_i;
            sort_trig_o  <= (state_d == ST_FIRE);
            meas_valid_o <= decide_c;

            // Arming only accumulates while staying in IDLE
            if ((state_q == ST_IDLE) && (state_d == ST_IDLE))
                armed_q <= armed_q | !above_c;
            else
                armed_q <= 1'b0;

            if ((state_q == ST_IDLE) && (state_d == ST_DROPLET)) begin
                width_q <= CW'(1);
                peak_q  <= adc_q;
            end else if (enable_i && (state_q == ST_DROPLET) && above_c) begin
                if (width_q != WIDTH_SAT) width_q <= width_q + CW'(1);
                if (adc_q > peak_q)       peak_q  <= adc_q;
            end

            if (decide_c) begin
                len_q         <= sort_len_i;
                last_peak_o   <= peak_q;
                last_width_o  <= width_q;
                last_sorted_o <= sort_c;
                droplet_cnt_o <= droplet_cnt_o + 32'd1;
                if (sort_c) sorted_cnt_o <= sorted_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// Directed bench for the FADS sorter: measurement, windows, trigger timing,
// enable/reset behaviour and width saturation on a narrow-counter instance.
module tb_red_pitaya_fads_sorter;

    logic               adc_clk_i = 1'b0;
    logic               adc_rstn_i;
    logic signed [13:0] adc_i, det_thr, low_thr, high_thr;
    logic               enable;
    logic [15:0]        min_w, max_w, dly, len;
    logic [3:0]         min4, max4, dly4, len4;

    logic               sort_trig_o, meas_valid_o, last_sorted_o;
    logic signed [13:0] last_peak_o;
    logic [15:0]        last_width_o;
    logic [31:0]        droplet_cnt_o, sorted_cnt_o;
    logic [1:0]         state_o;

    logic               trig4, mv4, sorted4;
    logic signed [13:0] peak4;
    logic [3:0]         width4;
    logic [31:0]        dcnt4, scnt4;
    logic [1:0]         state4;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_drop = 0;
    int exp_sort = 0;
    int trig_rise, trig_cnt, mv_cnt;

    always #5 adc_clk_i = ~adc_clk_i;

    red_pitaya_fads_sorter #(.DW(14), .CW(16)) dut (
        .adc_clk_i(adc_clk_i), .adc_rstn_i(adc_rstn_i), .adc_i(adc_i),
        .enable_i(enable), .det_thr_i(det_thr), .low_thr_i(low_thr),
        .high_thr_i(high_thr), .min_width_i(min_w), .max_width_i(max_w),
        .sort_delay_i(dly), .sort_len_i(len), .sort_trig_o(sort_trig_o),
        .meas_valid_o(meas_valid_o), .last_peak_o(last_peak_o),
        .last_width_o(last_width_o), .last_sorted_o(last_sorted_o),
        .droplet_cnt_o(droplet_cnt_o), .sorted_cnt_o(sorted_cnt_o),
        .state_o(state_o)
    );

    red_pitaya_fads_sorter #(.DW(14), .CW(4)) dut4 (
        .adc_clk_i(adc_clk_i), .adc_rstn_i(adc_rstn_i), .adc_i(adc_i),
        .enable_i(enable), .det_thr_i(det_thr), .low_thr_i(low_thr),
        .high_thr_i(high_thr), .min_width_i(min4), .max_width_i(max4),
        .sort_delay_i(dly4), .sort_len_i(len4), .sort_trig_o(trig4),
        .meas_valid_o(mv4), .last_peak_o(peak4), .last_width_o(width4),
        .last_sorted_o(sorted4), .droplet_cnt_o(dcnt4), .sorted_cnt_o(scnt4),
        .state_o(state4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge adc_clk_i);
        #1;
    endtask

    // Drive n samples at v, then one sample at 0; returns just after the edge
    // that captured the ending sample.
    task automatic droplet(input int v, input int n);
        adc_i = 14'(v);
        repeat (n) step();
        adc_i = '0;
        step();
    endtask

    // Index 0 is the current cycle; records trigger rise/length and extra strobes.
    task automatic observe(input int n);
        trig_rise = -1;
        trig_cnt  = 0;
        mv_cnt    = 0;
        for (int i = 0; i < n; i++) begin
            if (sort_trig_o) begin
                if (trig_rise < 0) trig_rise = i;
                trig_cnt++;
            end
            if (meas_valid_o && (i > 0)) mv_cnt++;
            step();
        end
    endtask

    task automatic run_droplet(input string tag, input int v, input int n,
                               input logic sorted, input int exp_trig);
        droplet(v, n);
        step();
        exp_drop++;
        if (sorted) exp_sort++;
        chk({tag, "_mv"},     64'(meas_valid_o),  64'd1);
        chk({tag, "_peak"},   64'(last_peak_o),   64'(v));
        chk({tag, "_width"},  64'(last_width_o),  64'(n));
        chk({tag, "_sorted"}, 64'(last_sorted_o), 64'(sorted));
        chk({tag, "_dcnt"},   64'(droplet_cnt_o), 64'(exp_drop));
        chk({tag, "_scnt"},   64'(sorted_cnt_o),  64'(exp_sort));
        observe(12);
        chk({tag, "_trig"},   64'(trig_cnt),      64'(exp_trig));
        chk({tag, "_state"},  64'(state_o),       64'd0);
    endtask

    initial begin
        adc_rstn_i = 1'b0;
        enable = 1'b1;
        adc_i = '0;
        det_thr = 14'sd50; low_thr = 14'sd15; high_thr = 14'sd255;
        min_w = 16'd5; max_w = 16'd20; dly = 16'd3; len = 16'd4;
        min4 = 4'd1; max4 = 4'd15; dly4 = 4'd0; len4 = 4'd1;
        repeat (3) step();
        chk("rst_trig",  64'(sort_trig_o),   64'd0);
        chk("rst_mv",    64'(meas_valid_o),  64'd0);
        chk("rst_peak",  64'(last_peak_o),   64'd0);
        chk("rst_width", 64'(last_width_o),  64'd0);
        chk("rst_dcnt",  64'(droplet_cnt_o), 64'd0);
        chk("rst_scnt",  64'(sorted_cnt_o),  64'd0);
        chk("rst_state", 64'(state_o),       64'd0);
        adc_rstn_i = 1'b1;
        repeat (3) step();

        // Nominal sorted droplet; delay/len changed after decision must not matter
        droplet(200, 10);
        chk("t1_mv_early", 64'(meas_valid_o), 64'd0);
        step();
        exp_drop++; exp_sort++;
        chk("t1_mv",     64'(meas_valid_o),  64'd1);
        chk("t1_peak",   64'(last_peak_o),   64'd200);
        chk("t1_width",  64'(last_width_o),  64'd10);
        chk("t1_sorted", 64'(last_sorted_o), 64'd1);
        chk("t1_dcnt",   64'(droplet_cnt_o), 64'd1);
        chk("t1_scnt",   64'(sorted_cnt_o),  64'd1);
        chk("t1_trig0",  64'(sort_trig_o),   64'd0);
        chk("t1_state",  64'(state_o),       64'd2);
        dly = 16'd9; len = 16'd1;
        observe(12);
        chk("t1_rise",   64'(trig_rise), 64'd3);
        chk("t1_len",    64'(trig_cnt),  64'd4);
        chk("t1_mvonce", 64'(mv_cnt),    64'd0);
        chk("t1_idle",   64'(state_o),   64'd0);
        dly = 16'd3; len = 16'd4;

        // Window rejections and inclusive/exclusive boundaries
        run_droplet("t2_peak300", 300, 10, 1'b0, 0);
        run_droplet("t2_w3",      200, 3,  1'b0, 0);
        run_droplet("t2_peak255", 255, 10, 1'b0, 0);
        run_droplet("t2_p254w5",  254, 5,  1'b1, 4);
        run_droplet("t2_w20",     200, 20, 1'b1, 4);
        run_droplet("t2_w21",     200, 21, 1'b0, 0);

        // Droplet during DELAY/FIRE, held high past FIRE exit
        droplet(200, 8);
        step();
        exp_drop++; exp_sort++;
        chk("t3_mv",    64'(meas_valid_o), 64'd1);
        chk("t3_state", 64'(state_o),      64'd2);
        adc_i = 14'sd200;
        observe(14);
        chk("t3_trig",  64'(trig_cnt),      64'd4);
        chk("t3_nomv",  64'(mv_cnt),        64'd0);
        chk("t3_idle",  64'(state_o),       64'd0);
        chk("t3_dcnt",  64'(droplet_cnt_o), 64'(exp_drop));
        adc_i = '0;
        repeat (3) step();
        run_droplet("t3_next", 120, 6, 1'b1, 4);

        // Zero delay, one-cycle trigger
        dly = 16'd0; len = 16'd1;
        droplet(200, 8);
        step();
        exp_drop++; exp_sort++;
        chk("t4_trig_now", 64'(sort_trig_o),  64'd1);
        chk("t4_state",    64'(state_o),      64'd3);
        chk("t4_scnt",     64'(sorted_cnt_o), 64'(exp_sort));
        step();
        chk("t4_trig_off", 64'(sort_trig_o),  64'd0);
        chk("t4_idle",     64'(state_o),      64'd0);
        repeat (2) step();
        // Zero length: sorted and counted, no pulse
        dly = 16'd2; len = 16'd0;
        run_droplet("t4_len0", 200, 8, 1'b1, 0);

        // Enable dropped mid-DROPLET aborts the measurement
        dly = 16'd3; len = 16'd4;
        adc_i = 14'sd200;
        repeat (4) step();
        chk("t5_in_drop", 64'(state_o), 64'd1);
        enable = 1'b0;
        step();
        chk("t5_dis_idle", 64'(state_o),      64'd0);
        chk("t5_dis_mv",   64'(meas_valid_o), 64'd0);
        adc_i = '0;
        step();
        enable = 1'b1;
        repeat (3) step();
        chk("t5_dcnt_hold", 64'(droplet_cnt_o), 64'(exp_drop));

        // Enable dropped mid-FIRE drops the trigger at the next edge
        dly = 16'd0; len = 16'd8;
        droplet(200, 8);
        step();
        exp_drop++; exp_sort++;
        chk("t5_fire", 64'(sort_trig_o), 64'd1);
        repeat (2) step();
        enable = 1'b0;
        step();
        chk("t5_fire_off",   64'(sort_trig_o),   64'd0);
        chk("t5_fire_idle",  64'(state_o),       64'd0);
        chk("t5_dcnt_kept",  64'(droplet_cnt_o), 64'(exp_drop));
        chk("t5_scnt_kept",  64'(sorted_cnt_o),  64'(exp_sort));
        chk("t5_peak_kept",  64'(last_peak_o),   64'd200);
        enable = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-FIRE
        droplet(200, 8);
        step();
        chk("t5_fire2", 64'(sort_trig_o), 64'd1);
        step();
        #3;
        adc_rstn_i = 1'b0;
        #1;
        chk("t5_rst_trig",  64'(sort_trig_o),   64'd0);
        chk("t5_rst_state", 64'(state_o),       64'd0);
        chk("t5_rst_dcnt",  64'(droplet_cnt_o), 64'd0);
        chk("t5_rst_scnt",  64'(sorted_cnt_o),  64'd0);
        chk("t5_rst_width", 64'(last_width_o),  64'd0);
        step();
        adc_rstn_i = 1'b1;
        repeat (3) step();

        // Width saturation on the 4-bit counter instance
        dly = 16'd3; len = 16'd4;
        droplet(200, 30);
        step();
        chk("t6_mv4",     64'(mv4),           64'd1);
        chk("t6_width4",  64'(width4),        64'd15);
        chk("t6_peak4",   64'(peak4),         64'd200);
        chk("t6_sorted4", 64'(sorted4),       64'd1);
        chk("t6_width16", 64'(last_width_o),  64'd30);
        chk("t6_sorted",  64'(last_sorted_o), 64'd0);
        chk("t6_dcnt",    64'(droplet_cnt_o), 64'd1);
        chk("t6_scnt",    64'(sorted_cnt_o),  64'd0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
